// File: rtl/vram_arbiter.sv
// Frame-memory arbiter: display scan reads always win, buffered pixel writes
// drain through the single RAM port during blanking, one access per cycle.
module vram_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int COLOR_W    = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk_div,
    input  logic               rst,
    input  logic [9:0]         h_addr,
    input  logic [9:0]         v_addr,
    input  logic               disp_valid,
    input  logic               wr_valid,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [COLOR_W-1:0] wr_data,
    output logic               wr_ready,
    output logic [2:0]         wr_pending,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_we,
    output logic [COLOR_W-1:0] mem_wdata,
    input  logic [COLOR_W-1:0] mem_rdata,
    output logic [23:0]        pix_data,
    output logic               pix_valid
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ADDR_W + COLOR_W;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t                       state, state_nx;
    logic [FIFO_DEPTH-1:0][EW-1:0] fifo_q;
    logic [PW-1:0]                rd_ptr, wr_ptr;
    logic [CW-1:0]                count;
    logic                         push, pop;
    logic [2:0]                   vld_pipe;
    logic                         unused;

    // Rows 512..1023 alias rows 0..511, so the top row bit is dropped.
    assign unused = v_addr[9];

    always_comb begin
        state_nx = IDLE;
        if (disp_valid)
            state_nx = SCAN;
        else if (count != '0)
            state_nx = DRAIN;
    end

    assign wr_ready   = (count != CW'(FIFO_DEPTH));
    assign push       = wr_valid && wr_ready;
    assign pop        = (state_nx == DRAIN);
    assign wr_pending = 3'(count);
    assign mem_we     = (state == DRAIN);
    assign pix_valid  = vld_pipe[2];

    always_ff @(posedge clk_div) begin
        if (push)
            fifo_q[wr_ptr] <= {wr_addr, wr_data};
    end

    always_ff @(posedge clk_div) begin
        if (rst) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            vld_pipe  <= '0;
            pix_data  <= '0;
        end else begin
            state    <= state_nx;
            vld_pipe <= {vld_pipe[1:0], disp_valid};
            // vld_pipe[1] tags the RAM word arriving this cycle
            pix_data <= vld_pipe[1] ? {mem_rdata[11:8], 4'h0, mem_rdata[7:4], 4'h0,
                                       mem_rdata[3:0], 4'h0} : 24'h0;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (!push && pop)
                count <= count - 1'b1;
            case (state_nx)
                SCAN:    mem_addr <= ADDR_W'({h_addr, v_addr[8:0]});
                DRAIN:   {mem_addr, mem_wdata} <= fifo_q[rd_ptr];
                default: ;
            endcase
        end
    end
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameters: ADDR_W, default 19, frame-memory address width; COLOR_W, default 12, stored pixel width (4:4:4 RGB); FIFO_DEPTH, default 4, write-buffer depth (power of two, at least 2).
REQ-002 clk_div  in  1  pixel clock; all logic on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset, sampled on clk_div.
REQ-004 h_addr  in  10  current scan column from the VGA timing block.
REQ-005 v_addr  in  10  current scan row from the VGA timing block.
REQ-006 disp_valid  in  1  high while the scan position is in the visible area.
REQ-007 wr_valid  in  1  writer offers one pixel write.
REQ-008 wr_addr  in  ADDR_W  write address, formatted {column[9:0], row[8:0]}.
REQ-009 wr_data  in  COLOR_W  write pixel value.
REQ-010 wr_ready  out  1  the write buffer can accept a write this cycle.
REQ-011 wr_pending  out  3  number of buffered writes not yet committed, 0..FIFO_DEPTH.
REQ-012 mem_addr  out  ADDR_W  single-port synchronous RAM address.
REQ-013 mem_we  out  1  RAM write enable.
REQ-014 mem_wdata  out  COLOR_W  RAM write data.
REQ-015 mem_rdata  in  COLOR_W  RAM read data, valid one cycle after the address.
REQ-016 pix_data  out  24  expanded RGB888 pixel for the display.
REQ-017 pix_valid  out  1  pix_data belongs to a visible pixel.

Function
REQ-018 The arbiter SHALL make one RAM access per cycle and SHALL choose it with a registered-output FSM that has three states: SCAN, DRAIN and IDLE.
REQ-019 Next-state rule: if disp_valid=1, the next state is SCAN; else if the buffer is non-empty, DRAIN; else IDLE. Display reads always have absolute priority.
REQ-020 SCAN: mem_addr={h_addr, v_addr[8:0]} and mem_we=0. Row bit 9 is ignored, so rows 512..1023 alias rows 0..511 without error.
REQ-021 DRAIN: pop the FIFO head, drive mem_addr=head address, mem_wdata=head data and mem_we=1, committing exactly one write per cycle.
REQ-022 IDLE: mem_we=0, and mem_addr holds its previous value.
REQ-023 mem_addr, mem_we and mem_wdata SHALL be registered outputs, updated on the same edge as the state register.
REQ-024 Read pipeline: an h_addr/v_addr pair sampled at edge t produces mem_rdata after edge t+1 and is registered to pix_data at edge t+2, a fixed 2-cycle latency.
REQ-025 pix_valid SHALL be disp_valid delayed by 2 cycles.
REQ-026 Expansion: pix_data = {mem_rdata[11:8], 4'h0, mem_rdata[7:4], 4'h0, mem_rdata[3:0], 4'h0}.
REQ-027 When the delayed valid is 0, pix_data SHALL be 24'h000000.
REQ-028 The write buffer is a FIFO of {wr_addr, wr_data}. wr_ready = (wr_pending != FIFO_DEPTH), and a push occurs when wr_valid and wr_ready are both high.
REQ-029 wr_data and wr_addr SHALL be ignored whenever wr_valid=0 or wr_ready=0; no overwrite and no error flag.
REQ-030 A push and a pop in the same cycle SHALL leave wr_pending unchanged and SHALL preserve ordering.
REQ-031 A push into an empty FIFO SHALL NOT be popped before the following cycle (no bypass).
REQ-032 Pointers wrap modulo FIFO_DEPTH. Writes commit in push order.
REQ-033 A write to the address currently being scanned is not forwarded. The display shows the new value from the next frame onward.

Reset
REQ-034 While rst=1 at an edge: state=IDLE, FIFO emptied (wr_pending=0, wr_ready=1), mem_we=0, mem_addr=0, mem_wdata=0, pix_data=0, pix_valid=0, and all pipeline valids cleared.
REQ-035 Reset asserted mid-drain SHALL discard all uncommitted writes. No partial or extra write SHALL be issued on the reset edge.
REQ-036 The first non-reset cycle follows REQ-019.

Verification
REQ-037 Read latency: memory model preloaded with 12'hA5C at {10'd3, 9'd7}; present h=3, v=7, disp_valid=1 at edge t -> pix_data=24'hA050C0 and pix_valid=1 after edge t+2, with mem_we=0 throughout.
REQ-038 Priority: disp_valid=1 while 3 writes are pushed -> mem_we stays 0 and wr_pending=3; drop disp_valid -> exactly 3 consecutive mem_we pulses, in push order, then state=IDLE and wr_pending=0.
REQ-039 Full: disp_valid=1 with 5 back-to-back wr_valid cycles -> the 5th is refused (wr_ready=0 when wr_pending=4); after blanking, only 4 writes appear at the RAM.
REQ-040 Simultaneous: during DRAIN with wr_pending=2, push 1 -> wr_pending stays 2; the new entry commits after the older two.
REQ-041 Reset mid-drain: wr_pending=3, assert rst during the first DRAIN cycle -> no further mem_we; wr_pending=0, wr_ready=1 and pix_data=0 on the next cycle.
REQ-042 Aliasing/blanking: v_addr=10'd515 -> mem_addr row field=9'd3; disp_valid=0 -> pix_data=0 two cycles later.
